// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Stall/flush/freeze control for the 5-stage RV64 pipeline.
//            Optional perf counters enabled by HAZARD_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic             i_ex_memread,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_mem_branch,
  input  logic             i_mem_alu_zero,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ready,
  output logic             o_pc_write,
  output logic             o_pc_src,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_flush,
  output logic             o_pipe_freeze,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_load_use_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic [CNT_W-1:0] o_freeze_cnt
);

  localparam int c_WCTR_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_WCTR_W-1:0] c_CTR_ONE   = c_WCTR_W'(1);
  localparam logic [c_WCTR_W-1:0] c_CTR_LIMIT = c_WCTR_W'(MEM_TIMEOUT);

  typedef enum logic [0:0] {
    S_RUN      = 1'b0,
    S_MEM_WAIT = 1'b1
  } state_t;

  state_t              r_state;
  logic [c_WCTR_W-1:0] r_wait_ctr;
  logic                r_mem_timeout;

  logic w_taken;
  logic w_lu;
  logic w_in_wait;
  logic w_done;
  logic w_expired;
  logic w_freeze;
  logic w_flush;
  logic w_bubble;

  assign w_taken = i_mem_branch & i_mem_alu_zero;
  assign w_lu    = i_ex_memread & (i_ex_rd != 5'd0) &
                   ((i_id_uses_rs1 & (i_ex_rd == i_id_rs1)) |
                    (i_id_uses_rs2 & (i_ex_rd == i_id_rs2)));

  // A dropped request while waiting counts as completion of the access.
  assign w_in_wait = (r_state == S_MEM_WAIT);
  assign w_done    = i_dmem_ready | ~i_dmem_req;
  assign w_expired = (r_wait_ctr == c_CTR_LIMIT);

  // On the exit cycle of a wait (done or abandoned) the memory access no
  // longer stalls; only branch and load-use rules apply.
  assign w_freeze = w_in_wait ? (~w_done & ~w_expired)
                              : (~w_taken & i_dmem_req & ~i_dmem_ready);
  assign w_flush  = ~w_freeze & w_taken;
  assign w_bubble = ~w_freeze & ~w_taken & w_lu;

  assign o_pc_write     = ~reset & ~w_freeze & ~w_bubble;
  assign o_if_id_write  = ~reset & ~w_freeze & ~w_bubble;
  assign o_pc_src       = ~reset & w_flush;
  assign o_if_id_flush  = ~reset & w_flush;
  assign o_id_ex_flush  = ~reset & (w_flush | w_bubble);
  assign o_ex_mem_flush = ~reset & w_flush;
  assign o_pipe_freeze  = ~reset & w_freeze;
  assign o_mem_timeout  = r_mem_timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_RUN;
      r_wait_ctr    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_freeze) begin
            r_state    <= S_MEM_WAIT;
            r_wait_ctr <= c_CTR_ONE;
          end
        end
        S_MEM_WAIT: begin
          if (w_freeze) begin
            r_wait_ctr <= r_wait_ctr + c_CTR_ONE;
          end else begin
            r_state    <= S_RUN;
            r_wait_ctr <= '0;
            if (!w_done) begin
              r_mem_timeout <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= S_RUN;
          r_wait_ctr <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_load_use_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_freeze_cnt;

  // Counters saturate rather than wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load_use_cnt <= '0;
      r_flush_cnt    <= '0;
      r_freeze_cnt   <= '0;
    end else begin
      if (w_bubble && (r_load_use_cnt != c_CNT_MAX)) begin
        r_load_use_cnt <= r_load_use_cnt + c_CNT_ONE;
      end
      if (w_flush && (r_flush_cnt != c_CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
      end
      if (w_freeze && (r_freeze_cnt != c_CNT_MAX)) begin
        r_freeze_cnt <= r_freeze_cnt + c_CNT_ONE;
      end
    end
  end

  assign o_load_use_cnt = r_load_use_cnt;
  assign o_flush_cnt    = r_flush_cnt;
  assign o_freeze_cnt   = r_freeze_cnt;
`else
  assign o_load_use_cnt = '0;
  assign o_flush_cnt    = '0;
  assign o_freeze_cnt   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  localparam int c_TMO   = 4;
  localparam int c_CNT_W = 4;
  localparam int c_CMAX  = 15;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit c_PERF = 1'b1;
`else
  localparam bit c_PERF = 1'b0;
`endif

  // {pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_freeze}
  localparam logic [6:0] c_ZERO  = 7'b0000000;
  localparam logic [6:0] c_DEF   = 7'b1010000;
  localparam logic [6:0] c_TAKEN = 7'b1111110;
  localparam logic [6:0] c_FRZ   = 7'b0000001;
  localparam logic [6:0] c_LU    = 7'b0000100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_memread = 0;
  logic mem_branch = 0, mem_alu_zero = 0, dmem_req = 0, dmem_ready = 0;
  logic pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
  logic pipe_freeze, mem_timeout;
  logic [c_CNT_W-1:0] load_use_cnt, flush_cnt, freeze_cnt;

  typedef struct {
    string      tag;
    logic [6:0] ctl;
    logic       tmo;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int m_lu = 0, m_fl = 0, m_fz = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(c_TMO), .CNT_W(c_CNT_W)) u_dut (
    .clk(clk), .reset(reset),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2),
    .i_ex_memread(ex_memread), .i_ex_rd(ex_rd),
    .i_mem_branch(mem_branch), .i_mem_alu_zero(mem_alu_zero),
    .i_dmem_req(dmem_req), .i_dmem_ready(dmem_ready),
    .o_pc_write(pc_write), .o_pc_src(pc_src),
    .o_if_id_write(if_id_write), .o_if_id_flush(if_id_flush),
    .o_id_ex_flush(id_ex_flush), .o_ex_mem_flush(ex_mem_flush),
    .o_pipe_freeze(pipe_freeze), .o_mem_timeout(mem_timeout),
    .o_load_use_cnt(load_use_cnt), .o_flush_cnt(flush_cnt),
    .o_freeze_cnt(freeze_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= c_CMAX) ? c_CMAX : v + 1;
  endfunction

  task automatic set_in(input logic br, input logic z, input logic req, input logic rdy,
                        input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic u1, input logic [4:0] rs2, input logic u2);
    mem_branch = br; mem_alu_zero = z; dmem_req = req; dmem_ready = rdy;
    ex_memread = ld; ex_rd = rd; id_rs1 = rs1; id_uses_rs1 = u1;
    id_rs2 = rs2; id_uses_rs2 = u2;
  endtask

  // One clock cycle: push expectation, sample at negedge, advance past posedge.
  task automatic cyc(input string tag, input logic [6:0] ctl, input logic tmo);
    exp_t e;
    e.tag = tag; e.ctl = ctl; e.tmo = tmo;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    if (reset) begin
      m_lu = 0; m_fl = 0; m_fz = 0;
    end
    check({e.tag, ".ctl"}, 32'({pc_write, pc_src, if_id_write, if_id_flush,
                               id_ex_flush, ex_mem_flush, pipe_freeze}), 32'(e.ctl));
    check({e.tag, ".tmo"}, 32'(mem_timeout), 32'(e.tmo));
    check({e.tag, ".lu_cnt"}, 32'(load_use_cnt), c_PERF ? 32'(m_lu) : 32'd0);
    check({e.tag, ".fl_cnt"}, 32'(flush_cnt), c_PERF ? 32'(m_fl) : 32'd0);
    check({e.tag, ".fz_cnt"}, 32'(freeze_cnt), c_PERF ? 32'(m_fz) : 32'd0);
    @(posedge clk);
    #1;
    if (!reset) begin
      if (e.ctl == c_TAKEN) m_fl = sat(m_fl);
      if (e.ctl == c_LU)    m_lu = sat(m_lu);
      if (e.ctl == c_FRZ)   m_fz = sat(m_fz);
    end
  endtask

  initial begin
    // Reset held: everything low.
    cyc("rst", c_ZERO, 1'b0);
    reset = 1'b0;
    cyc("idle", c_DEF, 1'b0);

    // Load-use detection
    set_in(0,0,0,0, 1,5'd5,5'd5,1,5'd0,0); cyc("lu_rs1", c_LU, 1'b0);
    set_in(0,0,0,0, 1,5'd0,5'd0,1,5'd0,1); cyc("lu_x0", c_DEF, 1'b0);
    set_in(0,0,0,0, 1,5'd5,5'd5,0,5'd5,0); cyc("lu_nouse", c_DEF, 1'b0);
    set_in(0,0,0,0, 0,5'd5,5'd5,1,5'd0,0); cyc("lu_noload", c_DEF, 1'b0);
    set_in(0,0,0,0, 1,5'd7,5'd3,1,5'd7,1); cyc("lu_rs2", c_LU, 1'b0);

    // Taken branch beats load-use and memory stall
    set_in(1,1,1,0, 1,5'd5,5'd5,1,5'd0,0); cyc("tk_lu", c_TAKEN, 1'b0);
    set_in(1,0,0,0, 0,5'd0,5'd0,0,5'd0,0); cyc("ntk", c_DEF, 1'b0);

    // Memory wait of three cycles; taken/lu ignored while frozen
    set_in(0,0,1,0, 0,5'd0,5'd0,0,5'd0,0); cyc("mw1", c_FRZ, 1'b0);
    set_in(1,1,1,0, 1,5'd5,5'd5,1,5'd0,0); cyc("mw2", c_FRZ, 1'b0);
    set_in(0,0,1,0, 0,5'd0,5'd0,0,5'd0,0); cyc("mw3", c_FRZ, 1'b0);
    set_in(0,0,1,1, 1,5'd5,5'd5,1,5'd0,0); cyc("mw_rdy_lu", c_LU, 1'b0);
    check("freeze_cnt3", 32'(freeze_cnt), c_PERF ? 32'd3 : 32'd0);
    set_in(0,0,1,1, 0,5'd0,5'd0,0,5'd0,0); cyc("run_hit", c_DEF, 1'b0);

    // Watchdog: four freeze cycles then abandon
    set_in(0,0,1,0, 0,5'd0,5'd0,0,5'd0,0);
    for (int i = 0; i < c_TMO; i++) cyc("tmo_frz", c_FRZ, 1'b0);
    cyc("tmo_exit", c_DEF, 1'b0);
    dmem_req = 1'b0;
    cyc("tmo_sticky1", c_DEF, 1'b1);
    cyc("tmo_sticky2", c_DEF, 1'b1);

    // Request withdrawn while waiting ends the wait
    set_in(0,0,1,0, 0,5'd0,5'd0,0,5'd0,0); cyc("wd_frz", c_FRZ, 1'b1);
    dmem_req = 1'b0; cyc("wd_exit", c_DEF, 1'b1);
    cyc("wd_run", c_DEF, 1'b1);

    // Reset mid-wait
    set_in(0,0,1,0, 0,5'd0,5'd0,0,5'd0,0);
    cyc("rmw1", c_FRZ, 1'b1);
    cyc("rmw2", c_FRZ, 1'b1);
    reset = 1'b1;
    cyc("rmw_rst", c_ZERO, 1'b0);
    reset = 1'b0;
    dmem_req = 1'b0;
    cyc("rmw_post", c_DEF, 1'b0);

    // Flush counter saturation
    set_in(1,1,0,0, 0,5'd0,5'd0,0,5'd0,0);
    for (int i = 0; i < 20; i++) cyc("sat_tk", c_TAKEN, 1'b0);
    check("flush_sat", 32'(flush_cnt), c_PERF ? 32'd15 : 32'd0);
    set_in(0,0,0,0, 0,5'd0,5'd0,0,5'd0,0);
    cyc("end_idle", c_DEF, 1'b0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Produces the stall/flush/write-enable controls consumed by the IF/ID, ID/EX and EX/MEM pipeline registers and the PC of the 5-stage RV64 core.
- Detects load-use hazards in ID.
- Redirects and flushes on a branch resolved taken in MEM.
- Freezes the whole pipeline while a data-memory access waits on a ready handshake, with a watchdog timeout.

Parameters:
- MEM_TIMEOUT, 16: maximum freeze cycles for one data-memory access before it is abandoned (≥2).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_memread  in  1  EX instruction is a load
- ex_rd  in  5  rd of the EX instruction
- mem_branch  in  1  MEM instruction is a branch
- mem_alu_zero  in  1  branch condition true in MEM
- dmem_req  in  1  MEM stage issues a load or store this cycle
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC register enable
- pc_src  out  1  1 = load branch target into PC
- if_id_write  out  1  IF/ID enable
- if_id_flush  out  1  IF/ID flush
- id_ex_flush  out  1  ID/EX flush (bubble)
- ex_mem_flush  out  1  EX/MEM flush
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB contents
- mem_timeout  out  1  sticky watchdog error
- load_use_cnt  out  CNT_W  load-use stall count
- flush_cnt  out  CNT_W  taken-branch flush count
- freeze_cnt  out  CNT_W  memory freeze cycle count

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk.
- Reset state:
  - State = RUN, wait_ctr = 0, mem_timeout = 0, all counters = 0.
  - While reset is high, pc_write = 0, if_id_write = 0, and all flush/freeze/pc_src outputs are 0.
- Output timing: control outputs are combinational from current state and inputs (same-cycle). State, wait_ctr and counters update on the posedge.
- Definitions:
  - taken = mem_branch & mem_alu_zero.
  - lu = ex_memread & ex_rd≠0 & ((id_uses_rs1 & ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
- Default (RUN, no event): pc_write = 1, if_id_write = 1, all others 0.
- RUN priority 1, taken: pc_src = 1, pc_write = 1, if_id_flush = 1, id_ex_flush = 1, ex_mem_flush = 1 for exactly that cycle. lu and dmem signals are ignored that cycle. Stay in RUN.
- RUN priority 2, dmem_req & !dmem_ready: pipe_freeze = 1, pc_write = 0, if_id_write = 0, no flushes. Next state MEM_WAIT, wait_ctr ← 1.
- RUN priority 3, lu: pc_write = 0, if_id_write = 0, id_ex_flush = 1. One bubble per detection; lu re-evaluates every cycle.
- RUN, dmem_req & dmem_ready: normal advance.
- MEM_WAIT, !dmem_ready & wait_ctr < MEM_TIMEOUT: freeze outputs as above, wait_ctr++. lu and taken are ignored.
- MEM_WAIT, dmem_ready: outputs per RUN rules (lu honoured, taken honoured), next state RUN, wait_ctr ← 0.
- MEM_WAIT, !dmem_ready & wait_ctr == MEM_TIMEOUT: mem_timeout ← 1 (sticky until reset), outputs per RUN rules, next state RUN, wait_ctr ← 0.
- Maximum freeze per access = MEM_TIMEOUT cycles.
- dmem_req deasserting in MEM_WAIT is treated as dmem_ready = 1.
- Reset asserted mid-wait aborts immediately to RUN with the reset values above.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - load_use_cnt increments on each cycle lu causes a bubble.
  - flush_cnt increments on each taken flush.
  - freeze_cnt increments on each cycle pipe_freeze = 1.
  - All three saturate at all-ones with no wrap.
- Undefined: the counter ports remain and are tied to 0, with no counter flops.

Test Plan:
- Load-use: ex_memread = 1, ex_rd = 5, id_rs1 = 5, id_uses_rs1 = 1 for one cycle → pc_write = 0, if_id_write = 0, id_ex_flush = 1 that cycle. With ex_rd = 0, or id_uses_rs1 = 0 and id_uses_rs2 = 0 → no stall.
- Taken branch with simultaneous lu: mem_branch = 1, mem_alu_zero = 1, lu true → pc_src = 1, all three flushes = 1, pc_write = 1, no stall. With mem_alu_zero = 0 → default outputs.
- Memory wait: dmem_req = 1 with dmem_ready low for 3 cycles then high → pipe_freeze = 1 for exactly 3 cycles, released in the ready cycle. freeze_cnt = 3 with HAZARD_PERF_CNT_EN.
- Timeout: MEM_TIMEOUT = 4, dmem_req = 1, dmem_ready stuck 0 → 4 freeze cycles, then mem_timeout = 1 persists, state back to RUN, pc_write = 1.
- Reset mid-wait: assert reset after 2 freeze cycles → outputs zero immediately. After release, default RUN outputs, mem_timeout = 0, counters = 0.
- Saturation (CNT_W = 4, HAZARD_PERF_CNT_EN): 20 consecutive taken cycles → flush_cnt = 15 and holds.
